// File: rtl/obi_sram_pkg.sv
// Shared helpers for the pipelined OBI SRAM slave.
//
// Contents:
//   obi_align_bits  - number of byte-offset address bits for a data width
//                     (log2 of bytes per word), used for alignment and
//                     word-index extraction.
//   obi_word_index  - word index of a byte address relative to a base.
//   obi_addr_err    - access error: below base, misaligned, or past DEPTH.
//
// Address arithmetic is done on 64-bit values so one helper serves any
// ADDR_WIDTH up to 64.
package obi_sram_pkg;

  function automatic int unsigned obi_align_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [63:0] obi_word_index(input logic [63:0]   addr,
                                                 input logic [63:0]   base,
                                                 input int unsigned   align_bits);
    return (addr - base) >> align_bits;
  endfunction

  function automatic logic obi_addr_err(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input int unsigned align_bits,
                                        input int unsigned depth);
    logic [63:0] mask;
    mask = (64'd1 << align_bits) - 64'd1;
    return (addr < base) ||
           ((addr & mask) != 64'd0) ||
           (obi_word_index(addr, base, align_bits) >= 64'(depth));
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// Response FIFO for the OBI SRAM slave.
//
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   push, push_data write one entry (caller guarantees not full)
//   pop, pop_data   pop_data always shows the head; pop advances it
//                   (caller guarantees not empty)
//   full, empty     occupancy flags
//   count           number of stored entries, $clog2(FIFO_DEPTH+1) bits
//
// Pointers wrap modulo FIFO_DEPTH, so non-power-of-two depths work.
module obi_resp_fifo #(
  parameter type         entry_t    = logic,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            push,
  input  entry_t                          push_data,
  input  logic                            pop,
  output entry_t                          pop_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are deliberately left out of reset; entries are
  // only observed through the reset pointers/count, and a reset network on
  // every word would prevent RAM inference.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/obi_sram_slave_pipe.sv
// Pipelined OBI slave in front of an internal word-aligned SRAM.
//
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   obi_req_i/gnt_o   A-channel handshake; gnt derives from registers only
//   obi_addr_i        byte address (up to 64 bits)
//   obi_we_i          1 = write
//   obi_be_i          byte enables
//   obi_wdata_i       write data
//   obi_rvalid_o      response available (response FIFO not empty)
//   obi_rready_i      master accepts the response
//   obi_rdata_o       read data (0 for writes, errors, and when idle)
//   obi_err_o         access error (below base, misaligned, past DEPTH)
//
// Pipeline: accept edge -> A-stage register; next edge commits the SRAM
// write (if any) and pushes the response. Responses return in order.
//
// Optional build macro OBI_SRAM_SLAVE_ID_EN adds parameter ID_WIDTH and
// ports obi_aid_i / obi_rid_o; the id travels with its response.
module obi_sram_slave_pipe
  import obi_sram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 64,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
`ifdef OBI_SRAM_SLAVE_ID_EN
  ,
  parameter int unsigned           ID_WIDTH   = 4
`endif
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o
`ifdef OBI_SRAM_SLAVE_ID_EN
  ,
  input  logic [ID_WIDTH-1:0]     obi_aid_i,
  output logic [ID_WIDTH-1:0]     obi_rid_o
`endif
);

  localparam int unsigned BE_W       = DATA_WIDTH / 8;
  localparam int unsigned ALIGN_BITS = obi_align_bits(DATA_WIDTH);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W      = CNT_W + 1;

  // The A-stage keeps only the word index; the full address is consumed by
  // the error check at accept.
  typedef struct packed {
    logic [IDX_W-1:0]      addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  err;
`ifdef OBI_SRAM_SLAVE_ID_EN
    logic [ID_WIDTH-1:0]   aid;
`endif
  } a_stage_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
`ifdef OBI_SRAM_SLAVE_ID_EN
    logic [ID_WIDTH-1:0]   rid;
`endif
  } resp_t;

  a_stage_t              a_d, a_q;
  logic                  a_valid;
  logic                  accept;
  resp_t                 push_resp, head_resp;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [OCC_W-1:0]      occupancy;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Credits count the A-stage too, and a same-cycle pop is not credited,
  // so gnt never depends on this cycle's inputs.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(a_valid);
  assign obi_gnt_o = (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = obi_req_i && obi_gnt_o;

  always_comb begin
    a_d       = '0;
    a_d.addr  = IDX_W'(obi_word_index(64'(obi_addr_i), 64'(BASE_ADDR), ALIGN_BITS));
    a_d.we    = obi_we_i;
    a_d.be    = obi_be_i;
    a_d.wdata = obi_wdata_i;
    a_d.err   = obi_addr_err(64'(obi_addr_i), 64'(BASE_ADDR), ALIGN_BITS, DEPTH);
`ifdef OBI_SRAM_SLAVE_ID_EN
    a_d.aid   = obi_aid_i;
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) a_valid <= 1'b0;
    else         a_valid <= accept;
  end

  // Payload is qualified by a_valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) a_q <= a_d;
  end

  // Commit: per-byte write. Dropping a_valid on reset cancels a pending write.
  always_ff @(posedge clk_i) begin
    if (a_valid && a_q.we && !a_q.err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_q.be[i]) mem[a_q.addr][i*8 +: 8] <= a_q.wdata[i*8 +: 8];
      end
    end
  end

  // NOTE: every combinational output gets a default before any condition,
  // which keeps always_comb free of inferred latches.
  always_comb begin
    push_resp     = '0;
    push_resp.err = a_q.err;
    if (!a_q.we && !a_q.err) push_resp.rdata = mem[a_q.addr];
`ifdef OBI_SRAM_SLAVE_ID_EN
    push_resp.rid = a_q.aid;
`endif
  end

  obi_resp_fifo #(
    .entry_t    (resp_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push       (a_valid),
    .push_data  (push_resp),
    .pop        (obi_rvalid_o && obi_rready_i),
    .pop_data   (head_resp),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign obi_rvalid_o = !fifo_empty;

  always_comb begin
    obi_rdata_o = '0;
    obi_err_o   = 1'b0;
`ifdef OBI_SRAM_SLAVE_ID_EN
    obi_rid_o   = '0;
`endif
    if (obi_rvalid_o) begin
      obi_rdata_o = head_resp.rdata;
      obi_err_o   = head_resp.err;
`ifdef OBI_SRAM_SLAVE_ID_EN
      obi_rid_o   = head_resp.rid;
`endif
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(a_valid && fifo_full));
  a_r_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (obi_rvalid_o && !obi_rready_i) |=> ($stable(obi_rdata_o) && $stable(obi_err_o)));
  a_gnt_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown(obi_gnt_o));
`endif

endmodule

// File: tb/tb_obi_sram_slave_pipe.sv
// Self-checking bench for obi_sram_slave_pipe (default build, 32-bit data,
// DEPTH=64, FIFO_DEPTH=4, BASE_ADDR=0).
//
// A transaction-level model (word array plus an in-order response queue)
// predicts rvalid/rdata/err/gnt every cycle; directed sections also check
// literal values from the response log.
module tb_obi_sram_slave_pipe;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic        obi_rready_i;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;

  always #5 clk_i = ~clk_i;

  obi_sram_slave_pipe #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (64),
    .FIFO_DEPTH (4),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rready_i (obi_rready_i),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [31:0] mm [64];
  rsp_t        cq[$];    // committed responses not yet taken by the master
  rsp_t        got[$];   // responses taken by the master, in order
  bit          pend_v;   // accepted but not yet committed
  bit          pend_we;
  logic [31:0] pend_addr, pend_wdata;
  logic [3:0]  pend_be;
  int          acc_count = 0;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 64);
  endfunction

  // Apply one accepted request: returns its response and updates memory.
  function automatic rsp_t model_commit(input bit we, input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] wd);
    rsp_t r;
    r.rdata = 32'h0;
    r.err   = addr_bad(a);
    if (!r.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mm[a / 4][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        r.rdata = mm[a / 4];
      end
    end
    return r;
  endfunction

  initial begin : monitor
    bit do_pop, do_acc, n_we;
    logic [31:0] n_addr, n_wd;
    logic [3:0]  n_be;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        cq.delete();
        pend_v = 1'b0;
        check("mon_rst_rvalid", obi_rvalid_o, 1'b0);
        continue;
      end
      check("mon_rvalid", obi_rvalid_o, cq.size() > 0);
      if (cq.size() > 0) begin
        check("mon_rdata", obi_rdata_o, cq[0].rdata);
        check("mon_err", obi_err_o, cq[0].err);
      end else begin
        check("mon_idle_rdata", obi_rdata_o, 32'h0);
        check("mon_idle_err", obi_err_o, 1'b0);
      end
      check("mon_gnt", obi_gnt_o, (cq.size() + int'(pend_v)) < 4);
      do_pop = (cq.size() > 0) && obi_rready_i;
      do_acc = obi_req_i && obi_gnt_o;
      n_we = obi_we_i; n_addr = obi_addr_i; n_be = obi_be_i; n_wd = obi_wdata_i;
      @(posedge clk_i);
      if (reset_i) continue;
      if (do_pop) got.push_back(cq.pop_front());
      if (pend_v) cq.push_back(model_commit(pend_we, pend_addr, pend_be, pend_wdata));
      pend_v = do_acc;
      pend_we = n_we; pend_addr = n_addr; pend_be = n_be; pend_wdata = n_wd;
      if (do_acc) acc_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    int n = 0;
    obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = a; obi_be_i = be; obi_wdata_i = wd;
    @(negedge clk_i);
    while (!obi_gnt_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    if (!obi_gnt_o) check("gnt_wait_timeout", obi_gnt_o, 1'b1);
    @(posedge clk_i);
    #1;
    obi_req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((cq.size() != 0 || pend_v) && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", cq.size() + int'(pend_v), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int t0, acc0;
    reset_i = 1'b1; obi_req_i = 1'b0; obi_we_i = 1'b0; obi_addr_i = '0;
    obi_be_i = '0; obi_wdata_i = '0; obi_rready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_rvalid", obi_rvalid_o, 1'b0);
    check("rst_rdata", obi_rdata_o, 32'h0);
    check("rst_err", obi_err_o, 1'b0);
    check("rst_gnt", obi_gnt_o, 1'b1);
    @(posedge clk_i); #1;

    // Full-word write then read with latency check
    issue(1, 32'h10, 4'hF, 32'hDEADBEEF);
    drain();
    issue(0, 32'h10, 4'hF, 32'h0);
    @(negedge clk_i);
    check("lat_rvalid_c1", obi_rvalid_o, 1'b0);
    @(negedge clk_i);
    check("lat_rvalid_c2", obi_rvalid_o, 1'b1);
    check("lat_rdata", obi_rdata_o, 32'hDEADBEEF);
    check("lat_err", obi_err_o, 1'b0);
    drain();

    // Byte-enabled merge
    got.delete();
    issue(1, 32'h20, 4'hF, 32'h11223344);
    issue(1, 32'h20, 4'b0001, 32'h000000AA);
    issue(0, 32'h20, 4'hF, 32'h0);
    drain();
    check("be_count", got.size(), 3);
    check("be_wr_rdata", got[0].rdata, 32'h0);
    check("be_merge", got[2].rdata, 32'h112233AA);

    // Errors, aliasing onto word 0, and be=0
    got.delete();
    issue(1, 32'h0,   4'hF, 32'h55555555);
    issue(0, 32'h100, 4'hF, 32'h0);
    issue(1, 32'h102, 4'hF, 32'hFFFFFFFF);
    issue(1, 32'h100, 4'hF, 32'hFFFFFFFF);
    issue(0, 32'h0,   4'hF, 32'h0);
    issue(1, 32'h0,   4'h0, 32'h0);
    issue(0, 32'h11,  4'hF, 32'h0);
    issue(0, 32'h0,   4'h0, 32'h0);
    drain();
    check("err_count", got.size(), 8);
    check("err_oor_err", got[1].err, 1'b1);
    check("err_oor_rdata", got[1].rdata, 32'h0);
    check("err_mis_wr", got[2].err, 1'b1);
    check("err_oor_wr", got[3].err, 1'b1);
    check("err_mem_kept", got[4].rdata, 32'h55555555);
    check("be0_no_err", got[5].err, 1'b0);
    check("err_mis_rd", got[6].err, 1'b1);
    check("be0_read_full", got[7].rdata, 32'h55555555);

    // Back-to-back reads
    for (int i = 0; i < 8; i++) issue(1, 32'h40 + 4*i, 4'hF, 32'h10000000 + i);
    drain();
    got.delete();
    t0 = int'($time);
    for (int i = 0; i < 8; i++) issue(0, 32'h40 + 4*i, 4'hF, 32'h0);
    check("b2b_cycles", (int'($time) - t0) / 10, 8);
    drain();
    check("b2b_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check("b2b_rdata", got[i].rdata, 32'h10000000 + i);

    // Backpressure: 4 accepts, then gnt low until drained
    got.delete();
    obi_rready_i = 1'b0;
    acc0 = acc_count;
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_be_i = 4'hF;
    repeat (10) begin
      obi_addr_i = 32'h40 + 4 * (acc_count - acc0);
      @(posedge clk_i); #1;
    end
    check("stall_accepts", acc_count - acc0, 4);
    @(negedge clk_i);
    check("stall_gnt_low", obi_gnt_o, 1'b0);
    check("stall_head", obi_rdata_o, 32'h10000000);
    obi_req_i = 1'b0;
    @(posedge clk_i); #1;
    obi_rready_i = 1'b1;
    drain();
    @(negedge clk_i);
    check("stall_gnt_back", obi_gnt_o, 1'b1);
    check("stall_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check("stall_order", got[i].rdata, 32'h10000000 + i);
    @(posedge clk_i); #1;

    // Reset with 2 buffered responses and a write in the A-stage
    issue(1, 32'h60, 4'hF, 32'hCAFEF00D);
    drain();
    obi_rready_i = 1'b0;
    issue(0, 32'h40, 4'hF, 32'h0);
    issue(0, 32'h44, 4'hF, 32'h0);
    issue(1, 32'h60, 4'hF, 32'h0BADBAD0);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_rvalid", obi_rvalid_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_rvalid", obi_rvalid_o, 1'b0);
    check("post_rst_gnt", obi_gnt_o, 1'b1);
    @(posedge clk_i); #1;
    obi_rready_i = 1'b1;
    got.delete();
    issue(0, 32'h60, 4'hF, 32'h0);
    drain();
    check("post_rst_count", got.size(), 1);
    check("post_rst_mem", got[0].rdata, 32'hCAFEF00D);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
